// File: rtl/sram_like_resp_if.sv
// SRAM-like initiator bus plus synchronous RAM port of sram_like_resp.
// Latency: none, wiring only.
// Backpressure: addr_ok stalls the initiator; data_ok cannot be stalled.
// Ports (slave = responder view):
//   req/wr/size/addr/wdata -> request in, addr_ok <- accept, data_ok/rdata <- completion
//   ram_en/ram_wen/ram_addr/ram_wdata <- RAM access, ram_rdata -> RAM read data
interface sram_like_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  req, wr, size, addr, wdata, ram_rdata,
    output addr_ok, data_ok, rdata, ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output req, wr, size, addr, wdata, ram_rdata,
    input  addr_ok, data_ok, rdata, ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/sram_like_resp.sv
// Queues SRAM-like requests and serves them one at a time against a synchronous RAM.
// Latency: data_ok DELAY+3 cycles after the handshake when idle; one completion per DELAY+3 cycles.
// Backpressure: addr_ok drops while the queue is full (no same-cycle bypass); data_ok is never stalled.
// Ports: clk, rst (async, active-high); bus = sram_like_resp_if.slave (initiator + RAM signals).
module sram_like_resp #(
  parameter int DEPTH = 4,
  parameter int DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  sram_like_resp_if.slave bus
);
  localparam int         PW        = $clog2(DEPTH);
  localparam logic [3:0] DELAY_CNT = 4'(DELAY);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  req_t        q_dat [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push_vld;
  logic        pop_vld;
  req_t        head;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        resp_wr;
  logic        resp_wr_nxt;
  logic        misaligned;
  logic [3:0]  head_wen;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  // Gated by rst so the initiator sees no accept while the block is held in reset.
  assign bus.addr_ok = bus.req && !full && !rst;
  assign push_vld = bus.req && bus.addr_ok;
  assign pop_vld  = (state == ACCESS);
  assign head     = q_dat[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Payload storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push_vld) q_dat[wr_ptr[PW-1:0]] <= {bus.wr, bus.size, bus.addr, bus.wdata};
  end

  // Byte strobes of the head entry; misaligned or illegal writes are suppressed.
  always_comb begin
    misaligned = 1'b0;
    head_wen   = 4'b0000;
    case (head.size)
      2'd0: head_wen = 4'b0001 << head.addr[1:0];
      2'd1: begin
        misaligned = head.addr[0];
        head_wen   = head.addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        misaligned = (head.addr[1:0] != 2'b00);
        head_wen   = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
    if (!head.wr || misaligned) head_wen = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      resp_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      resp_wr <= resp_wr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    resp_wr_nxt   = resp_wr;
    bus.ram_en    = 1'b0;
    bus.ram_wen   = 4'b0000;
    bus.ram_addr  = 32'h0;
    bus.ram_wdata = 32'h0;
    bus.data_ok   = 1'b0;
    bus.rdata     = 32'h0;
    case (state)
      IDLE: begin
        if (!empty) begin
          cnt_nxt   = DELAY_CNT;
          state_nxt = (DELAY_CNT == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.ram_en    = 1'b1;
        bus.ram_wen   = head_wen;
        bus.ram_addr  = {head.addr[31:2], 2'b00};
        bus.ram_wdata = head.wdata;
        // The entry is popped here, so remember its direction for the response.
        resp_wr_nxt   = head.wr;
        state_nxt     = RESP;
      end
      RESP: begin
        bus.data_ok = 1'b1;
        bus.rdata   = resp_wr ? 32'h0 : bus.ram_rdata;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: directed steps plus random traffic against a transaction-level model.
// Latency: model schedules each completion at max(accept, previous completion) + DELAY + 3.
// Backpressure: model accepts only while fewer than DEPTH entries await their RAM access.
module tb_sram_like_resp;
  localparam int DEPTH0 = 4;
  localparam int DELAY0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_like_resp_if bus0();
  sram_like_resp_if bus1();

  sram_like_resp #(.DEPTH(DEPTH0), .DELAY(DELAY0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_like_resp #(.DEPTH(2), .DELAY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Synchronous RAM behind dut0; word 0x100 holds DEADBEEF.
  logic [31:0] ram0 [1024] = '{64: 32'hDEADBEEF, default: 32'h0};
  always @(posedge clk) begin
    if (bus0.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus0.ram_wen[b]) ram0[bus0.ram_addr[11:2]][8*b +: 8] <= bus0.ram_wdata[8*b +: 8];
      bus0.ram_rdata <= ram0[bus0.ram_addr[11:2]];
    end
  end

  // Trivial RAM behind dut1: read data derived from the address.
  always @(posedge clk) begin
    if (bus1.ram_en) bus1.ram_rdata <= 32'hC0FFEE00 ^ bus1.ram_addr;
  end

  typedef struct {
    bit        wr;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        acc;
    int        done;
    bit [31:0] rd;
  } txn_t;

  txn_t        sched[$];
  logic [31:0] ref_mem [1024] = '{64: 32'hDEADBEEF, default: 32'h0};
  int          cyc = 0;
  int          last_done = -100;
  int          vectors = 0;
  int          miscompares = 0;
  int          z_idx = -1;

  function automatic bit [3:0] spec_wen(bit wr, bit [1:0] size, bit [31:0] a);
    if (!wr) return 4'b0000;
    case (size)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[0] ? 4'b0000 : (a[1] ? 4'b1100 : 4'b0011);
      2'd2:    return (a[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check dut0 (and dut1 when enabled) against the model, then advance.
  task automatic cycle(output bit hs);
    bit        e_aok, e_en, e_dok;
    bit [3:0]  e_wen;
    bit [31:0] e_addr, e_wdata, e_rdata;
    int        occ;
    txn_t      t;
    @(negedge clk);
    e_aok = 0; e_en = 0; e_dok = 0; e_wen = 0;
    e_addr = 0; e_wdata = 0; e_rdata = 0; occ = 0; hs = 0;
    if (rst) begin
      sched.delete();
      last_done = -100;
    end else begin
      foreach (sched[i]) begin
        if (sched[i].acc < cyc && sched[i].done - 1 >= cyc) occ++;
        if (sched[i].done - 1 == cyc) begin
          e_en    = 1;
          e_addr  = {sched[i].addr[31:2], 2'b00};
          e_wen   = spec_wen(sched[i].wr, sched[i].size, sched[i].addr);
          e_wdata = sched[i].wdata;
          if (sched[i].wr) begin
            for (int b = 0; b < 4; b++)
              if (e_wen[b]) ref_mem[sched[i].addr[11:2]][8*b +: 8] = sched[i].wdata[8*b +: 8];
          end else begin
            sched[i].rd = ref_mem[sched[i].addr[11:2]];
          end
        end
        if (sched[i].done == cyc) begin
          e_dok   = 1;
          e_rdata = sched[i].wr ? 32'h0 : sched[i].rd;
        end
      end
      e_aok = bus0.req && (occ < DEPTH0);
    end
    chk("addr_ok",   bus0.addr_ok,   e_aok);
    chk("data_ok",   bus0.data_ok,   e_dok);
    chk("rdata",     bus0.rdata,     e_rdata);
    chk("ram_en",    bus0.ram_en,    e_en);
    chk("ram_wen",   bus0.ram_wen,   e_wen);
    chk("ram_addr",  bus0.ram_addr,  e_addr);
    chk("ram_wdata", bus0.ram_wdata, e_wdata);
    if (z_idx >= 0) begin
      chk("z_addr_ok",  bus1.addr_ok,  z_idx == 0);
      chk("z_ram_en",   bus1.ram_en,   z_idx == 2);
      chk("z_ram_addr", bus1.ram_addr, (z_idx == 2) ? 32'h40 : 32'h0);
      chk("z_data_ok",  bus1.data_ok,  z_idx == 3);
      chk("z_rdata",    bus1.rdata,    (z_idx == 3) ? 32'hC0FFEE40 : 32'h0);
      z_idx++;
    end
    if (e_aok) begin
      t.wr = bus0.wr; t.size = bus0.size; t.addr = bus0.addr; t.wdata = bus0.wdata;
      t.acc = cyc;
      t.done = ((cyc > last_done) ? cyc : last_done) + DELAY0 + 3;
      t.rd = 0;
      last_done = t.done;
      sched.push_back(t);
      hs = 1;
    end
    while (sched.size() > 0 && sched[0].done < cyc) void'(sched.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit r, input bit w, input bit [1:0] s, input bit [31:0] a, input bit [31:0] d);
    bus0.req = r; bus0.wr = w; bus0.size = s; bus0.addr = a; bus0.wdata = d;
  endtask

  task automatic idle(input int n);
    bit hs;
    bus0.req = 0;
    for (int i = 0; i < n; i++) cycle(hs);
  endtask

  // Hold one request until accepted, bounded.
  task automatic issue(input bit w, input bit [1:0] s, input bit [31:0] a, input bit [31:0] d);
    bit hs;
    int n;
    hs = 0; n = 0;
    drive(1, w, s, a, d);
    while (!hs && n < 50) begin
      cycle(hs);
      n++;
    end
    chk("issue_accepted", hs, 1'b1);
    bus0.req = 0;
  endtask

  // Hold req high across a burst of random requests, each held until accepted.
  task automatic burst(input int cnt);
    bit        hs, bw[16];
    bit [1:0]  bs[16];
    bit [31:0] ba[16], bd[16];
    int        k, guard;
    for (int i = 0; i < cnt; i++) begin
      bw[i] = 1'($urandom_range(0, 1));
      bs[i] = 2'($urandom_range(0, 3));
      ba[i] = $urandom_range(0, 4095);
      bd[i] = $urandom;
    end
    k = 0; guard = 0;
    while (k < cnt && guard < 300) begin
      drive(1, bw[k], bs[k], ba[k], bd[k]);
      cycle(hs);
      if (hs) k++;
      guard++;
    end
    chk("burst_accepts", k, cnt);
    bus0.req = 0;
  endtask

  initial begin
    bit hs;
    bit pending;
    drive(1, 0, 2'd2, 32'h100, 32'h0);
    bus1.req = 0; bus1.wr = 0; bus1.size = 0; bus1.addr = 0; bus1.wdata = 0;

    // Reset with req high: everything must read zero.
    cycle(hs);
    cycle(hs);
    // First handshake in the first cycle after release; single read of 0x100.
    rst = 0;
    issue(0, 2'd2, 32'h100, 32'h0);
    idle(8);

    // Byte write to 0x203, then read it back.
    issue(1, 2'd0, 32'h203, 32'hAA000000);
    idle(6);
    issue(0, 2'd2, 32'h200, 32'h0);
    idle(6);

    // Misaligned half-word write is suppressed but still completes.
    issue(1, 2'd1, 32'h301, 32'h12345678);
    issue(0, 2'd2, 32'h300, 32'h0);
    idle(12);

    // Six back-to-back held requests into a 4-deep queue.
    burst(6);
    idle(40);

    // DELAY = 0 instance: read accepted in its cycle 0.
    z_idx = 0;
    bus1.req = 1; bus1.wr = 0; bus1.size = 2'd0; bus1.addr = 32'h42;
    cycle(hs);
    bus1.req = 0;
    repeat (4) cycle(hs);
    z_idx = -1;

    // Random traffic.
    pending = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        drive(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 4095), $urandom);
        pending = 1;
      end
      cycle(hs);
      if (hs) begin
        pending = 0;
        bus0.req = 0;
      end
    end
    idle(40);

    // Three queued, reset pulsed while the FSM waits, then a fresh read.
    burst(3);
    rst = 1;
    bus0.req = 1;
    cycle(hs);
    cycle(hs);
    rst = 0;
    issue(0, 2'd2, 32'h100, 32'h0);
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 Parameter DEPTH, default 4: request queue entries; power of two, 2..16.
REQ-002 Parameter DELAY, default 2: wait cycles between dequeue decision and RAM access; 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  1  initiator request valid; held high until addr_ok.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  write data, already lane-aligned by the initiator.
REQ-010 addr_ok  output  1  request accepted this cycle.
REQ-011 data_ok  output  1  one-cycle completion pulse, in request order.
REQ-012 rdata  output  32  read data, valid while data_ok is high.
REQ-013 ram_en  output  1  synchronous RAM access enable.
REQ-014 ram_wen  output  4  RAM byte write strobes.
REQ-015 ram_addr  output  32  RAM address, {addr[31:2],2'b00}.
REQ-016 ram_wdata  output  32  RAM write data.
REQ-017 ram_rdata  input  32  RAM read data; valid the cycle after ram_en.

Function
REQ-018 The block SHALL implement addr_ok combinationally as req && !full; handshake = req && addr_ok at a rising edge; no backpressure on data_ok.
REQ-019 The queue SHALL be a circular FIFO with read and write pointers of log2(DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = pointers equal; pointers wrap modulo 2*DEPTH.
REQ-020 Each queue entry SHALL store wr, size, addr and wdata captured at the handshake edge.
REQ-021 Full is evaluated on current state only: no bypass; a pop in the same cycle does not enable addr_ok.
REQ-022 The FSM SHALL have states IDLE, WAIT, ACCESS, RESP.
REQ-023 IDLE: if !empty, load the counter with DELAY and go to WAIT (DELAY > 0) or ACCESS (DELAY = 0); otherwise stay in IDLE.
REQ-024 WAIT: decrement the counter each cycle; go to ACCESS on the edge at which the counter equals 1.
REQ-025 ACCESS: drive ram_en = 1 for exactly one cycle with ram_addr, ram_wen and ram_wdata from the head entry; pop the head; go to RESP.
REQ-026 RESP: drive data_ok = 1 for exactly one cycle; go to IDLE.
REQ-027 Latency from the handshake cycle (cycle 0) with an idle FSM and an empty queue: data_ok SHALL assert in cycle DELAY+3.
REQ-028 Back-to-back queued requests SHALL complete one per DELAY+3 cycles.
REQ-029 Write strobes:
- size 0: 4'b0001 << addr[1:0].
- size 1: addr[1] ? 4'b1100 : 4'b0011.
- size 2: 4'b1111.
- Reads: 4'b0000.
REQ-030 Misaligned or illegal requests (size 1 with addr[0] = 1; size 2 with addr[1:0] != 0; size 3):
- Writes: ram_wen = 0, so the write is suppressed.
- Reads: performed normally.
- data_ok is still returned in order.
REQ-031 In RESP, rdata SHALL equal ram_rdata for reads and 32'h0 for writes; in all other cycles rdata SHALL be 32'h0.
REQ-032 Outside ACCESS, ram_en, ram_wen, ram_addr and ram_wdata SHALL be 0.
REQ-033 A handshake and a pop in the same cycle SHALL both take effect; the occupancy count is unchanged.

Reset
REQ-034 While rst is high, the block SHALL hold:
- Both pointers = 0.
- FSM = IDLE, counter = 0.
- addr_ok = 0, data_ok = 0, rdata = 0.
- ram_en = 0, ram_wen = 0, ram_addr = 0, ram_wdata = 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-flight requests; no data_ok SHALL follow for them after reset release.
REQ-036 The first handshake SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-037 DELAY = 2: single read of 0x100, ram_rdata = 32'hDEADBEEF -> ram_en in cycle 4 with ram_addr = 0x100, data_ok in cycle 5 with rdata = 32'hDEADBEEF.
REQ-038 Byte write to 0x203, wdata = 32'hAA000000 -> ram_wen = 4'b1000, ram_addr = 0x200, data_ok with rdata = 0.
REQ-039 DEPTH = 4: req held high for 6 consecutive requests -> the first 4 are accepted in consecutive cycles, addr_ok stays low while full, accepts resume one cycle after the first pop, and all 6 data_ok pulses arrive in order.
REQ-040 Half-word write to 0x301 -> ram_wen = 0, data_ok still pulses once.
REQ-041 3 requests queued, rst pulsed during WAIT -> all outputs 0 during reset, no data_ok after release, new read completes with the REQ-027 latency.
REQ-042 DELAY = 0: read accepted in cycle 0 -> ram_en in cycle 2, data_ok in cycle 3.
